// File: rtl/aes_sbox_sequencer_if.sv
// rtl/aes_sbox_sequencer_if.sv - control/status bundle of the AES S-box round sequencer
interface aes_sbox_sequencer_if;
    logic       i_start;
    logic       i_hold;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_round;
    logic [2:0] o_stage;
    logic       o_iss_valid;
    logic [4:0] o_iss_idx;
    logic       o_wb_valid;
    logic [4:0] o_wb_idx;
    logic       o_rnd_req;
    logic       o_addkey_en;
    logic       o_shiftmix_en;
    logic       o_mix_bypass;
    logic       o_key_upd_en;

    modport master (
        output i_start, i_hold,
        input  o_busy, o_done, o_round, o_stage, o_iss_valid, o_iss_idx, o_wb_valid,
               o_wb_idx, o_rnd_req, o_addkey_en, o_shiftmix_en, o_mix_bypass, o_key_upd_en
    );

    modport slave (
        input  i_start, i_hold,
        output o_busy, o_done, o_round, o_stage, o_iss_valid, o_iss_idx, o_wb_valid,
               o_wb_idx, o_rnd_req, o_addkey_en, o_shiftmix_en, o_mix_bypass, o_key_upd_en
    );
endinterface

// File: rtl/aes_sbox_sequencer.sv
// rtl/aes_sbox_sequencer.sv - AES round sequencer driving one shared, pipelined S-box
// Optional macro RAMBAM_SHARED_KEY_SBOX_EN: key-schedule bytes 16..19 also use the shared S-box.
module aes_sbox_sequencer #(
    parameter int SBOX_LAT = 7
) (
    input  logic               clk,
    input  logic               rst,
    aes_sbox_sequencer_if.slave io_bus
);
`ifdef RAMBAM_SHARED_KEY_SBOX_EN
    localparam logic [4:0] N_BYTES = 5'd20;
`else
    localparam logic [4:0] N_BYTES = 5'd16;
`endif
    localparam logic [SBOX_LAT-1:0] HEAD_BIT = SBOX_LAT'(1) << (SBOX_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_INIT = 3'd1, S_SUB = 3'd2,
        S_SHIFTMIX = 3'd3, S_ADDKEY = 3'd4, S_DONE = 3'd5
    } state_t;

    state_t              r_state, w_next;
    logic [3:0]          r_round;
    logic [4:0]          r_cnt;
    logic [SBOX_LAT-1:0] r_pipe_v;
    logic [4:0]          r_pipe_idx [SBOX_LAT];

    logic       w_issue, w_inflight, w_sub_done;
    logic       w_busy, w_done, w_wb_valid, w_addkey_en, w_shiftmix_en, w_mix_bypass;
    logic [4:0] w_iss_idx, w_wb_idx;

    logic       r_busy, r_done, r_iss_valid, r_wb_valid;
    logic       r_addkey_en, r_shiftmix_en, r_mix_bypass, r_key_upd_en;
    logic [3:0] r_round_out;
    logic [2:0] r_stage;
    logic [4:0] r_iss_idx, r_wb_idx;

    assign w_issue    = (r_state == S_SUB) && !io_bus.i_hold && (r_cnt < N_BYTES);
    // SUB is finished once every byte issued and only the head slot (or nothing) remains in flight
    assign w_inflight = |(r_pipe_v & ~HEAD_BIT);
    assign w_sub_done = (r_cnt == N_BYTES) && !w_inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!io_bus.i_hold) begin
            case (r_state)
                S_IDLE:     if (io_bus.i_start) w_next = S_INIT;
                S_INIT:     w_next = S_SUB;
                S_SUB:      if (w_sub_done) w_next = S_SHIFTMIX;
                S_SHIFTMIX: w_next = S_ADDKEY;
                S_ADDKEY:   w_next = (r_round == 4'd10) ? S_DONE : S_SUB;
                S_DONE:     w_next = S_IDLE;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy        = (r_state != S_IDLE);
        w_done        = (r_state == S_DONE);
        w_iss_idx     = w_issue ? r_cnt : 5'd0;
        w_wb_valid    = r_pipe_v[SBOX_LAT-1];
        w_wb_idx      = w_wb_valid ? r_pipe_idx[SBOX_LAT-1] : 5'd0;
        w_addkey_en   = (r_state == S_INIT) || (r_state == S_ADDKEY);
        w_shiftmix_en = (r_state == S_SHIFTMIX);
        w_mix_bypass  = w_shiftmix_en && (r_round == 4'd10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round <= 4'd0;
            r_cnt   <= 5'd0;
        end else begin
            if (r_state == S_IDLE && w_next == S_INIT)        r_round <= 4'd0;
            else if (r_state == S_INIT && w_next == S_SUB)    r_round <= 4'd1;
            else if (r_state == S_ADDKEY && w_next == S_SUB)  r_round <= r_round + 4'd1;
            if (w_next == S_SUB && r_state != S_SUB) r_cnt <= 5'd0;
            else if (w_issue)                        r_cnt <= r_cnt + 5'd1;
        end
    end

    // Latency tracker shifts every cycle, hold only stops new entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_v <= '0;
            for (int i = 0; i < SBOX_LAT; i++) r_pipe_idx[i] <= 5'd0;
        end else begin
            r_pipe_v[0]   <= w_issue;
            r_pipe_idx[0] <= w_iss_idx;
            for (int i = 1; i < SBOX_LAT; i++) begin
                r_pipe_v[i]   <= r_pipe_v[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_round_out   <= 4'd0;
            r_stage       <= 3'd0;
            r_iss_valid   <= 1'b0;
            r_iss_idx     <= 5'd0;
            r_wb_valid    <= 1'b0;
            r_wb_idx      <= 5'd0;
            r_addkey_en   <= 1'b0;
            r_shiftmix_en <= 1'b0;
            r_mix_bypass  <= 1'b0;
            r_key_upd_en  <= 1'b0;
        end else begin
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_round_out   <= r_round;
            r_stage       <= r_state;
            r_iss_valid   <= w_issue;
            r_iss_idx     <= w_iss_idx;
            r_wb_valid    <= w_wb_valid;
            r_wb_idx      <= w_wb_idx;
            r_addkey_en   <= w_addkey_en;
            r_shiftmix_en <= w_shiftmix_en;
            r_mix_bypass  <= w_mix_bypass;
            r_key_upd_en  <= w_shiftmix_en;
        end
    end

    assign io_bus.o_busy        = r_busy;
    assign io_bus.o_done        = r_done;
    assign io_bus.o_round       = r_round_out;
    assign io_bus.o_stage       = r_stage;
    assign io_bus.o_iss_valid   = r_iss_valid;
    assign io_bus.o_iss_idx     = r_iss_idx;
    assign io_bus.o_wb_valid    = r_wb_valid;
    assign io_bus.o_wb_idx      = r_wb_idx;
    assign io_bus.o_rnd_req     = r_iss_valid;
    assign io_bus.o_addkey_en   = r_addkey_en;
    assign io_bus.o_shiftmix_en = r_shiftmix_en;
    assign io_bus.o_mix_bypass  = r_mix_bypass;
    assign io_bus.o_key_upd_en  = r_key_upd_en;
endmodule

// File: tb/tb_aes_sbox_sequencer.sv
// tb/tb_aes_sbox_sequencer.sv - randomized self-checking bench for aes_sbox_sequencer
module tb_aes_sbox_sequencer;
    localparam int L = 7;
`ifdef RAMBAM_SHARED_KEY_SBOX_EN
    localparam int N = 20;
`else
    localparam int N = 16;
`endif
    localparam int NOMINAL = 1 + 10 * (N + L + 2) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    aes_sbox_sequencer_if u_if();

    aes_sbox_sequencer #(.SBOX_LAT(L)) u_dut (.clk(clk), .rst(rst), .io_bus(u_if));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: phase list walked per cycle, S-box results kept as (due cycle, index) queue
    int m_phase = 0, m_round = 0, m_issued = 0, m_t = 0;
    bit m_seen = 0;
    int q_due[$];
    int q_idx[$];
    int edge_cnt = 0, start_edge = 0, done_lat = -1, done_cnt = 0, max_iss = -1, wb_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_round = 0; m_issued = 0; m_seen = 0;
        q_due.delete(); q_idx.delete();
    endtask

    task automatic step(input logic s, input logic h);
        logic e_iss, e_wb;
        logic [4:0] e_iss_idx, e_wb_idx;
        int ph, rnd, this_edge;
        u_if.i_start = s;
        u_if.i_hold  = h;
        ph  = m_phase;
        rnd = m_round;
        e_iss = (ph == 2) && !h && (m_issued < N);
        e_iss_idx = e_iss ? 5'(m_issued) : 5'd0;
        e_wb = (q_due.size() > 0) && (q_due[0] == m_t);
        e_wb_idx = e_wb ? 5'(q_idx[0]) : 5'd0;
        if (e_iss) begin
            q_due.push_back(m_t + L);
            q_idx.push_back(m_issued);
            m_issued++;
        end
        if (e_wb) begin
            if (q_idx[0] == N - 1) m_seen = 1;
            void'(q_due.pop_front());
            void'(q_idx.pop_front());
        end
        this_edge = edge_cnt;
        if (!h) begin
            case (ph)
                0: if (s) begin m_phase = 1; m_round = 0; start_edge = this_edge; end
                1: begin m_phase = 2; m_round = 1; m_issued = 0; m_seen = 0; end
                2: if (m_seen) m_phase = 3;
                3: m_phase = 4;
                4: if (m_round == 10) m_phase = 5;
                   else begin m_phase = 2; m_round++; m_issued = 0; m_seen = 0; end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        chk("busy",        u_if.o_busy,        32'(ph != 0));
        chk("done",        u_if.o_done,        32'(ph == 5));
        chk("round",       u_if.o_round,       32'(rnd));
        chk("stage",       u_if.o_stage,       32'(ph));
        chk("iss_valid",   u_if.o_iss_valid,   32'(e_iss));
        chk("iss_idx",     u_if.o_iss_idx,     32'(e_iss_idx));
        chk("wb_valid",    u_if.o_wb_valid,    32'(e_wb));
        chk("wb_idx",      u_if.o_wb_idx,      32'(e_wb_idx));
        chk("rnd_req",     u_if.o_rnd_req,     32'(e_iss));
        chk("addkey_en",   u_if.o_addkey_en,   32'(ph == 1 || ph == 4));
        chk("shiftmix_en", u_if.o_shiftmix_en, 32'(ph == 3));
        chk("mix_bypass",  u_if.o_mix_bypass,  32'(ph == 3 && rnd == 10));
        chk("key_upd_en",  u_if.o_key_upd_en,  32'(ph == 3));
        m_t++;
        edge_cnt++;
        if (u_if.o_done === 1'b1) begin
            done_cnt++;
            if (done_lat < 0) done_lat = this_edge - start_edge;
        end
        if (u_if.o_iss_valid === 1'b1 && int'(u_if.o_iss_idx) > max_iss) max_iss = int'(u_if.o_iss_idx);
        if (u_if.o_wb_valid === 1'b1) wb_cnt++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  u_if.o_busy, 0);
        chk({tag, "_done"},  u_if.o_done, 0);
        chk({tag, "_round"}, u_if.o_round, 0);
        chk({tag, "_stage"}, u_if.o_stage, 0);
        chk({tag, "_iss"},   {u_if.o_iss_valid, u_if.o_iss_idx}, 0);
        chk({tag, "_wb"},    {u_if.o_wb_valid, u_if.o_wb_idx}, 0);
        chk({tag, "_ctl"},   {u_if.o_rnd_req, u_if.o_addkey_en, u_if.o_shiftmix_en,
                              u_if.o_mix_bypass, u_if.o_key_upd_en}, 0);
    endtask

    // One encryption; random hold percentage, optional random start while busy, optional 3-cycle hold after idx 5
    task automatic run_enc(input int hold_pct, input bit rand_start, input bit hold5);
        int guard, hcnt;
        logic s, h;
        done_lat = -1; done_cnt = 0; hcnt = 0;
        step(1'b1, 1'b0);
        guard = 0;
        while ((m_phase != 0 || u_if.o_busy !== 1'b0) && guard < 5000) begin
            h = ($urandom_range(99) < hold_pct);
            if (hold5) begin
                h = 1'b0;
                if (m_phase == 2 && m_round == 1 && m_issued == 6 && hcnt < 3) begin
                    h = 1'b1;
                    hcnt++;
                end
            end
            s = (rand_start && m_phase != 0) ? 1'($urandom_range(1)) : 1'b0;
            step(s, h);
            guard++;
        end
        chk("run_terminates", 32'(guard < 5000), 1);
        chk("done_pulses", done_cnt, 1);
    endtask

    initial begin
        int guard;
        u_if.i_start = 1'b0;
        u_if.i_hold  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        model_reset();

        repeat (3) step(1'b0, 1'b0);

        max_iss = -1;
        run_enc(0, 1'b0, 1'b0);
        chk("nominal_done_latency", done_lat, NOMINAL);
        chk("max_iss_idx", max_iss, N - 1);

        run_enc(0, 1'b0, 1'b1);
        chk("hold3_done_latency", done_lat, NOMINAL + 3);

        run_enc(15, 1'b1, 1'b0);
        run_enc(30, 1'b1, 1'b0);
        repeat (4) step(1'($urandom_range(1)) & 1'b0, 1'($urandom_range(1)));

        step(1'b1, 1'b0);
        guard = 0;
        while (!(m_phase == 2 && m_round == 4 && m_issued == 4) && guard < 2000) begin
            step(1'b0, 1'b0);
            guard++;
        end
        chk("reached_round4", 32'(guard < 2000), 1);
        chk("inflight_before_reset", q_due.size(), 4);
        rst = 1'b1;
        #2;
        chk_zero("midrun_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wb_cnt = 0;
        repeat (20) step(1'b0, 1'($urandom_range(1)));
        chk("no_wb_after_reset", wb_cnt, 0);

        run_enc(0, 1'b0, 1'b0);
        chk("post_reset_done_latency", done_lat, NOMINAL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_sbox_sequencer.md
AES_SBOX_SEQUENCER -- requirements
Module: aes_sbox_sequencer

Interface
REQ-001 Parameter SBOX_LAT, default 7: shared S-box pipeline latency in cycles, legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begin one encryption; sampled only in IDLE.
REQ-005 hold  input  1  freeze FSM, counters and issue; S-box pipeline tracking keeps running.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse in DONE state.
REQ-008 round  output  4  current round 0..10; also the rcon index.
REQ-009 stage  output  3  FSM state: IDLE=0, INIT=1, SUB=2, SHIFTMIX=3, ADDKEY=4, DONE=5.
REQ-010 iss_valid  output  1  byte issued to the shared S-box this cycle.
REQ-011 iss_idx  output  5  issued byte: 0..15 state bytes, 16..19 key bytes (rotated last key word).
REQ-012 wb_valid  output  1  S-box result available this cycle.
REQ-013 wb_idx  output  5  destination index of the result; same encoding as iss_idx.
REQ-014 rnd_req  output  1  request a fresh d-bit mask; equals iss_valid.
REQ-015 addkey_en  output  1  high in INIT and ADDKEY.
REQ-016 shiftmix_en  output  1  high in SHIFTMIX.
REQ-017 mix_bypass  output  1  high in SHIFTMIX of round 10; MixColumns skipped.
REQ-018 key_upd_en  output  1  high in SHIFTMIX; round-key XOR chain update.

Function
REQ-019 All outputs are registered Moore outputs decoded from FSM state and counters.
REQ-020 IDLE with start=1 -> INIT; round set to 0.
REQ-021 INIT lasts 1 cycle -> SUB; round set to 1.
REQ-022 SUB issues one byte per non-held cycle, iss_idx 0,1,...,N-1 in order; N=20, or 16 per Configuration.
REQ-023 Issue tracking: a SBOX_LAT-deep shift register of (valid, idx); wb_valid/wb_idx appear exactly SBOX_LAT cycles after the matching issue, regardless of hold.
REQ-024 SUB -> SHIFTMIX on the cycle after the wb_valid for idx N-1.
REQ-025 SUB duration with no hold is N+SBOX_LAT cycles.
REQ-026 SHIFTMIX lasts 1 cycle -> ADDKEY; ADDKEY lasts 1 cycle.
REQ-027 ADDKEY with round<10 -> SUB with round+1; with round=10 -> DONE.
REQ-028 DONE lasts 1 cycle -> IDLE; start in DONE is ignored.
REQ-029 Cycles per round with no hold: N+SBOX_LAT+2.
REQ-030 With no hold, done goes high 1+10*(N+SBOX_LAT+2)+1 cycles after the start edge (292 for N=20, SBOX_LAT=7).
REQ-031 hold=1 blocks all state transitions and issue, and forces iss_valid=0.
REQ-032 Writebacks continue during hold.
REQ-033 Under hold, the byte issue counter does not advance.
REQ-034 start while busy is ignored; a running encryption is never restarted.
REQ-035 Byte issue counter is 5 bits, cleared on entering SUB, saturates at N; it never wraps.

Reset
REQ-036 rst=1 forces IDLE immediately: round=0, stage=0, all 1-bit outputs 0, iss_idx=0, wb_idx=0.
REQ-037 rst=1 clears the issue-tracking shift register; in-flight S-box results are not reported after reset.
REQ-038 Reset mid-encryption is treated like any other reset: after release, the block waits in IDLE for a new start.

Configuration
REQ-039 With macro RAMBAM_SHARED_KEY_SBOX_EN defined, N=20 and the key-schedule bytes 16..19 pass through the shared S-box.
REQ-040 Without RAMBAM_SHARED_KEY_SBOX_EN, N=16 and indices 16..19 are never issued or written back, because the key schedule owns a dedicated S-box.
REQ-041 With RAMBAM_SHARED_KEY_SBOX_EN undefined and SBOX_LAT=7, done goes high 252 cycles after the start edge.

Verification
REQ-042 Scenario 1, nominal run: macro defined, SBOX_LAT=7, single start pulse, no hold -> round 1 begins cycle 2, done at cycle 292, done lasts 1 cycle, busy low at cycle 293.
REQ-043 Scenario 2, issue/writeback ordering: in round 1 issue idx 0..19 on SUB cycles 0..19 -> wb idx 0..19 on SUB cycles 7..26; SHIFTMIX on SUB cycle 27; mix_bypass=0.
REQ-044 Scenario 3, final round: in round 10 SHIFTMIX -> mix_bypass=1 and key_upd_en=1; in ADDKEY -> next state DONE.
REQ-045 Scenario 4, hold during SUB: hold=1 for 3 cycles after idx 5 issues -> no issue for 3 cycles, wb 0..5 still on schedule, done delayed by exactly 3 cycles to cycle 295.
REQ-046 Scenario 5, reset mid-run: rst pulses in round 4 SUB with 4 bytes in flight -> all outputs 0 immediately, no wb_valid after release; a new start gives done 292 cycles later.
REQ-047 Scenario 6, macro undefined: run with SBOX_LAT=7 -> max iss_idx 15, done at cycle 252; start pulsed while busy has no effect.
